// File: rtl/eth_tx_pkt_buf.sv
// Single-frame store-and-forward byte buffer feeding eth_tx through a pop-strobe handshake.
// Define ETH_TX_PAD_EN to zero-pad short frames up to MIN_LEN on the read side.
module eth_tx_pkt_buf #(
  parameter int DEPTH   = 2048,
  parameter int ADDR_W  = 11,
  parameter int MIN_LEN = 60
) (
  input  logic              Clk,
  input  logic              Rstn,
  input  logic [7:0]        AXIS_Master_tdata,
  input  logic              AXIS_Master_tvalid,
  input  logic              AXIS_Master_tlast,
  output logic              AXIS_Slave_tready,
  output logic [7:0]        Eth_Byte,
  output logic              Eth_Byte_Valid,
  output logic              Eth_Byte_Last,
  input  logic              Eth_Byte_Rd,
  output logic              Eth_Pkt_Rdy,
  output logic [ADDR_W:0]   Frame_Len,
  output logic              Ovf_Err,
  output logic              Tx_Done
);

`ifdef ETH_TX_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   MIN_LEN_W = (ADDR_W+1)'(MIN_LEN);
  localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  typedef enum logic [1:0] {FILL, READY, DRAIN} state_t;

  state_t            state;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   rx_len;
  logic              drop;

  logic              accept;
  logic              write_en;
  logic              pop;
  logic [ADDR_W:0]   next_len;
  logic [ADDR_W:0]   padded_len;
  logic [ADDR_W:0]   rd_idx;
  logic [ADDR_W:0]   last_idx;

  assign accept     = AXIS_Master_tvalid && AXIS_Slave_tready;
  assign write_en   = accept && !drop && (rx_len != DEPTH_W);
  assign pop        = Eth_Byte_Rd && Eth_Byte_Valid;
  assign next_len   = rx_len + LEN_ONE;
  assign padded_len = (PAD_EN && (next_len < MIN_LEN_W)) ? MIN_LEN_W : next_len;
  assign rd_idx     = {1'b0, rd_ptr};
  assign last_idx   = Frame_Len - LEN_ONE;

  always_ff @(posedge Clk) begin
    if (write_en) begin
      mem[wr_ptr] <= AXIS_Master_tdata;
    end
  end

  // Bytes past the received count are padding and are produced without touching the RAM.
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      state             <= FILL;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      rx_len            <= '0;
      drop              <= 1'b0;
      AXIS_Slave_tready <= 1'b1;
      Eth_Byte          <= 8'h00;
      Eth_Byte_Valid    <= 1'b0;
      Eth_Byte_Last     <= 1'b0;
      Eth_Pkt_Rdy       <= 1'b0;
      Frame_Len         <= '0;
      Ovf_Err           <= 1'b0;
      Tx_Done           <= 1'b0;
    end else begin
      Ovf_Err <= 1'b0;
      Tx_Done <= 1'b0;
      case (state)
        FILL: begin
          if (accept) begin
            if (drop || (rx_len == DEPTH_W)) begin
              if (AXIS_Master_tlast) begin
                Ovf_Err <= 1'b1;
                drop    <= 1'b0;
                wr_ptr  <= '0;
                rx_len  <= '0;
              end else begin
                drop <= 1'b1;
              end
            end else begin
              wr_ptr <= wr_ptr + PTR_ONE;
              rx_len <= next_len;
              if (AXIS_Master_tlast) begin
                state             <= READY;
                AXIS_Slave_tready <= 1'b0;
                Eth_Pkt_Rdy       <= 1'b1;
                Frame_Len         <= padded_len;
              end
            end
          end
        end
        READY, DRAIN: begin
          if (pop) begin
            Eth_Byte_Valid <= 1'b0;
            Eth_Byte_Last  <= 1'b0;
            Eth_Pkt_Rdy    <= 1'b0;
            if (Eth_Byte_Last) begin
              Tx_Done           <= 1'b1;
              state             <= FILL;
              AXIS_Slave_tready <= 1'b1;
              wr_ptr            <= '0;
              rd_ptr            <= '0;
              rx_len            <= '0;
              Frame_Len         <= '0;
              Eth_Byte          <= 8'h00;
            end else begin
              rd_ptr <= rd_ptr + PTR_ONE;
              state  <= DRAIN;
            end
          end else if (!Eth_Byte_Valid) begin
            Eth_Byte       <= (rd_idx < rx_len) ? mem[rd_ptr] : 8'h00;
            Eth_Byte_Valid <= 1'b1;
            Eth_Byte_Last  <= (rd_idx == last_idx);
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_pkt_buf.sv
// Randomized directed bench for eth_tx_pkt_buf; expected bytes come from the sent frame
// (zero-padded to MIN_LEN when ETH_TX_PAD_EN is defined).
module tb_eth_tx_pkt_buf;
  localparam int DEPTH   = 2048;
  localparam int ADDR_W  = 11;
  localparam int MIN_LEN = 60;
  localparam int BUDGET  = 20000;

  logic              Clk = 1'b0;
  logic              Rstn = 1'b0;
  logic [7:0]        AXIS_Master_tdata = 8'h00;
  logic              AXIS_Master_tvalid = 1'b0;
  logic              AXIS_Master_tlast = 1'b0;
  logic              AXIS_Slave_tready;
  logic [7:0]        Eth_Byte;
  logic              Eth_Byte_Valid;
  logic              Eth_Byte_Last;
  logic              Eth_Byte_Rd = 1'b0;
  logic              Eth_Pkt_Rdy;
  logic [ADDR_W:0]   Frame_Len;
  logic              Ovf_Err;
  logic              Tx_Done;

  int total = 0;
  int bad = 0;
  int tx_cnt = 0;
  int ovf_cnt = 0;
  bit saw_rdy = 1'b0;

  always #5 Clk = ~Clk;

  eth_tx_pkt_buf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .MIN_LEN(MIN_LEN)) dut (
    .Clk(Clk),
    .Rstn(Rstn),
    .AXIS_Master_tdata(AXIS_Master_tdata),
    .AXIS_Master_tvalid(AXIS_Master_tvalid),
    .AXIS_Master_tlast(AXIS_Master_tlast),
    .AXIS_Slave_tready(AXIS_Slave_tready),
    .Eth_Byte(Eth_Byte),
    .Eth_Byte_Valid(Eth_Byte_Valid),
    .Eth_Byte_Last(Eth_Byte_Last),
    .Eth_Byte_Rd(Eth_Byte_Rd),
    .Eth_Pkt_Rdy(Eth_Pkt_Rdy),
    .Frame_Len(Frame_Len),
    .Ovf_Err(Ovf_Err),
    .Tx_Done(Tx_Done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // While a frame is held, the input side must be back-pressured.
  always @(negedge Clk) begin
    if (Tx_Done === 1'b1) tx_cnt++;
    if (Ovf_Err === 1'b1) ovf_cnt++;
    if (Eth_Pkt_Rdy === 1'b1) saw_rdy = 1'b1;
    if (Rstn && (Eth_Byte_Valid === 1'b1 || Eth_Pkt_Rdy === 1'b1))
      checkOutput("backpressure", AXIS_Slave_tready, 0);
  end

  function automatic int expLen(input int n);
    int r;
    r = n;
`ifdef ETH_TX_PAD_EN
    if (n < MIN_LEN) r = MIN_LEN;
`endif
    return r;
  endfunction

  task automatic buildExpected(input logic [7:0] f[$], output logic [7:0] e[$]);
    e = f;
    while (e.size() < expLen(f.size())) e.push_back(8'h00);
  endtask

  // Called on a negedge; returns on the negedge after the tlast byte is accepted.
  task automatic applyStimulus(input logic [7:0] f[$], input bit gaps, output bit ok);
    int waited;
    ok = 1'b1;
    for (int i = 0; i < f.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        AXIS_Master_tvalid = 1'b0;
        AXIS_Master_tdata  = 8'($urandom);
        AXIS_Master_tlast  = 1'($urandom);
        @(negedge Clk);
      end
      AXIS_Master_tdata  = f[i];
      AXIS_Master_tlast  = (i == f.size() - 1);
      AXIS_Master_tvalid = 1'b1;
      waited = 0;
      while (AXIS_Slave_tready !== 1'b1 && waited < BUDGET) begin
        @(negedge Clk);
        waited++;
      end
      if (AXIS_Slave_tready !== 1'b1) begin
        checkOutput("tready_timeout", AXIS_Slave_tready, 1);
        ok = 1'b0;
        break;
      end
      @(negedge Clk);
    end
    AXIS_Master_tvalid = 1'b0;
    AXIS_Master_tlast  = 1'b0;
  endtask

  // Pops until Last (or max_pops when non-zero); returns on the negedge after the final pop.
  task automatic collectFrame(input bit hold, input int max_pops, output logic [7:0] got[$],
                              output logic lasts[$], output int gaps_bad, output int first_pop);
    int  cycles;
    int  last_pop;
    bit  done;
    logic rd;
    cycles = 0; last_pop = -1; done = 1'b0;
    got = {}; lasts = {}; gaps_bad = 0; first_pop = -1;
    while (!done && cycles < BUDGET && got.size() < DEPTH + 100) begin
      rd = hold ? 1'b1 : 1'($urandom_range(0, 1));
      if (rd && Eth_Byte_Valid === 1'b1) begin
        got.push_back(Eth_Byte);
        lasts.push_back(Eth_Byte_Last);
        if (last_pop < 0) first_pop = cycles;
        else if (cycles - last_pop != 2) gaps_bad++;
        last_pop = cycles;
        if (Eth_Byte_Last === 1'b1 || got.size() == max_pops) done = 1'b1;
      end
      Eth_Byte_Rd = rd;
      @(negedge Clk);
      cycles++;
    end
    Eth_Byte_Rd = 1'b0;
    if (!done) checkOutput("drain_timeout", {31'd0, done}, 1);
  endtask

  task automatic compareFrame(input string name, input logic [7:0] got[$], input logic lasts[$],
                              input logic [7:0] e[$]);
    int n;
    checkOutput({name, "_count"}, got.size(), e.size());
    n = (got.size() < e.size()) ? got.size() : e.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_byte%0d", name, i), got[i], e[i]);
      checkOutput($sformatf("%s_last%0d", name, i), lasts[i], (i == e.size() - 1));
    end
  endtask

  // Entered in the first READY cycle.
  task automatic drainAndCheck(input logic [7:0] f[$], input bit hold, input string name);
    logic [7:0] e[$];
    logic [7:0] got[$];
    logic       lasts[$];
    int gb, fp, n0;
    buildExpected(f, e);
    checkOutput({name, "_pkt_rdy"}, Eth_Pkt_Rdy, 1);
    checkOutput({name, "_frame_len"}, Frame_Len, expLen(f.size()));
    checkOutput({name, "_tready_low"}, AXIS_Slave_tready, 0);
    checkOutput({name, "_valid_first"}, Eth_Byte_Valid, 0);
    n0 = tx_cnt;
    collectFrame(hold, 0, got, lasts, gb, fp);
    checkOutput({name, "_tx_done"}, Tx_Done, 1);
    checkOutput({name, "_tready_after"}, AXIS_Slave_tready, 1);
    checkOutput({name, "_pkt_rdy_after"}, Eth_Pkt_Rdy, 0);
    compareFrame(name, got, lasts, e);
    if (hold) begin
      checkOutput({name, "_first_pop"}, fp, 1);
      checkOutput({name, "_pop_spacing"}, gb, 0);
    end
    @(negedge Clk);
    checkOutput({name, "_tx_done_pulse"}, Tx_Done, 0);
    checkOutput({name, "_tx_done_once"}, tx_cnt - n0, 1);
  endtask

  task automatic runFrame(input logic [7:0] f[$], input bit gaps, input bit hold, input string name);
    bit ok;
    applyStimulus(f, gaps, ok);
    if (ok) drainAndCheck(f, hold, name);
  endtask

  task automatic randFrame(input int n, output logic [7:0] f[$]);
    f = {};
    for (int i = 0; i < n; i++) f.push_back(8'($urandom));
  endtask

  task automatic runOversize(input int n, input string name);
    logic [7:0] f[$];
    bit ok;
    int o0;
    randFrame(n, f);
    o0 = ovf_cnt;
    saw_rdy = 1'b0;
    applyStimulus(f, 1'b0, ok);
    if (ok) begin
      checkOutput({name, "_ovf_pulse"}, Ovf_Err, 1);
      checkOutput({name, "_no_rdy"}, Eth_Pkt_Rdy, 0);
      checkOutput({name, "_tready"}, AXIS_Slave_tready, 1);
      @(negedge Clk);
      checkOutput({name, "_ovf_clear"}, Ovf_Err, 0);
      checkOutput({name, "_ovf_once"}, ovf_cnt - o0, 1);
      checkOutput({name, "_rdy_never"}, {31'd0, saw_rdy}, 0);
    end
  endtask

  initial begin
    logic [7:0] f[$];
    logic [7:0] f2[$];
    logic [7:0] got[$];
    logic       lasts[$];
    int gb, fp, tc, oc;
    bit ok, ok2;

    repeat (3) @(negedge Clk);
    checkOutput("rst_tready", AXIS_Slave_tready, 1);
    checkOutput("rst_byte", Eth_Byte, 0);
    checkOutput("rst_len", Frame_Len, 0);
    checkOutput("rst_valid", Eth_Byte_Valid, 0);
    checkOutput("rst_last", Eth_Byte_Last, 0);
    checkOutput("rst_rdy", Eth_Pkt_Rdy, 0);
    checkOutput("rst_ovf", Ovf_Err, 0);
    checkOutput("rst_done", Tx_Done, 0);
    Rstn = 1'b1;
    @(negedge Clk);
    checkOutput("idle_tready", AXIS_Slave_tready, 1);

    $display("[TB] 64-byte counting frame");
    f = {};
    for (int i = 0; i < 64; i++) f.push_back(8'(i));
    runFrame(f, 1'b0, 1'b0, "count64");

    $display("[TB] short frame");
    f = {};
    for (int i = 0; i < 14; i++) f.push_back(8'(8'hA0 + i));
    runFrame(f, 1'b1, 1'b0, "short14");

    $display("[TB] single-byte and random frames");
    randFrame(1, f);
    runFrame(f, 1'b0, 1'b1, "one");
    for (int k = 0; k < 3; k++) begin
      randFrame($urandom_range(20, 200), f);
      runFrame(f, 1'b1, 1'b0, $sformatf("rand%0d", k));
    end

    $display("[TB] oversize frames");
    runOversize(DEPTH + 2, "ovf2050");
    randFrame(64, f);
    runFrame(f, 1'b1, 1'b0, "after_ovf");
    runOversize(DEPTH + 1, "ovf2049");

    $display("[TB] full-depth frame");
    randFrame(DEPTH, f);
    runFrame(f, 1'b0, 1'b1, "full");

    $display("[TB] second frame offered during drain");
    randFrame(64, f);
    randFrame(64, f2);
    applyStimulus(f, 1'b1, ok);
    if (ok) begin
      fork
        begin
          collectFrame(1'b0, 0, got, lasts, gb, fp);
          checkOutput("overlap_f1_done", Tx_Done, 1);
        end
        begin
          applyStimulus(f2, 1'b0, ok2);
        end
      join
      compareFrame("overlap_f1", got, lasts, f);
      if (ok2) drainAndCheck(f2, 1'b0, "overlap_f2");
    end

    $display("[TB] reset during drain");
    randFrame(100, f);
    applyStimulus(f, 1'b0, ok);
    if (ok) begin
      collectFrame(1'b0, 10, got, lasts, gb, fp);
      checkOutput("mid_pops", got.size(), 10);
      for (int i = 0; i < got.size(); i++)
        checkOutput($sformatf("mid_byte%0d", i), got[i], f[i]);
      tc = tx_cnt;
      oc = ovf_cnt;
      #2 Rstn = 1'b0;
      #1;
      checkOutput("mid_rst_tready", AXIS_Slave_tready, 1);
      checkOutput("mid_rst_byte", Eth_Byte, 0);
      checkOutput("mid_rst_len", Frame_Len, 0);
      checkOutput("mid_rst_valid", Eth_Byte_Valid, 0);
      checkOutput("mid_rst_last", Eth_Byte_Last, 0);
      checkOutput("mid_rst_rdy", Eth_Pkt_Rdy, 0);
      @(negedge Clk);
      Rstn = 1'b1;
      @(negedge Clk);
      checkOutput("mid_rst_no_done", tx_cnt - tc, 0);
      checkOutput("mid_rst_no_ovf", ovf_cnt - oc, 0);
      randFrame(64, f);
      runFrame(f, 1'b0, 1'b0, "post_reset");
    end

    $display("[TB] held pop strobe");
    randFrame(64, f);
    runFrame(f, 1'b0, 1'b1, "held_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
